demux_sel_ctrl: RTL

Upstream control stage for the 1-to-4 LED demultiplexer. It turns a raw push-button and two slide switches into a registered 2-bit select, `sel`, which drives the demux `control` input directly. The button is synchronised and debounced, and each clean press steps the select. An optional auto-scan mode steps the select periodically, so the demux output walks across the four LEDs without user input.

---
 rtl/demux_sel_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/demux_sel_ctrl.sv
// Select controller for the 1-to-4 LED demux: synchronises and debounces a push-button,
// and steps a registered 2-bit select on each clean press or on each auto-scan tick.
module demux_sel_ctrl #(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int SCAN_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       sw_auto,
  input  logic       sw_dir,
  output logic [1:0] sel,
  output logic       sel_pulse,
  output logic       btn_state,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);

  logic [1:0]       btn_sync, auto_sync, dir_sync;
  logic             btn_s, auto_s, dir_s;
  deb_state_t       state, next_state;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] scnt;
  logic             press, tick, step;
  logic             in_wait, dcnt_clr;
  logic [1:0]       sel_d;
  logic             btn_state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync  <= 2'b00;
      auto_sync <= 2'b00;
      dir_sync  <= 2'b00;
    end else begin
      btn_sync  <= {btn_sync[0], btn};
      auto_sync <= {auto_sync[0], sw_auto};
      dir_sync  <= {dir_sync[0], sw_dir};
    end
  end

  assign btn_s  = btn_sync[1];
  assign auto_s = auto_sync[1];
  assign dir_s  = dir_sync[1];

  // Debounce state register; dcnt restarts on every entry into a wait state.
  assign in_wait  = (state == PRESS_WAIT) || (state == RELEASE_WAIT);
  assign dcnt_clr = (next_state != state) &&
                    ((next_state == PRESS_WAIT) || (next_state == RELEASE_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RELEASED;
      dcnt  <= '0;
    end else begin
      state <= next_state;
      if (dcnt_clr)
        dcnt <= '0;
      else if (in_wait)
        dcnt <= dcnt + 1'b1;
      else
        dcnt <= '0;
    end
  end

  always_comb begin
    next_state = state;
    press      = 1'b0;
    case (state)
      RELEASED: begin
        if (btn_s) next_state = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          next_state = RELEASED;
        end else if (dcnt == DEB_LAST) begin
          next_state = PRESSED;
          press      = 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) next_state = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (btn_s)
          next_state = PRESSED;
        else if (dcnt == DEB_LAST)
          next_state = RELEASED;
      end
      default: next_state = RELEASED;
    endcase
  end

  // Scan counter is held at zero in manual mode so re-entering auto starts a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      scnt <= '0;
    else if (!auto_s || scnt == SCAN_LAST)
      scnt <= '0;
    else
      scnt <= scnt + 1'b1;
  end

  assign tick = auto_s && (scnt == SCAN_LAST);
  assign step = press || tick;

  always_comb begin
    sel_d       = sel;
    btn_state_d = (next_state == PRESSED) || (next_state == RELEASE_WAIT);
    if (step)
      sel_d = dir_s ? (sel - 2'd1) : (sel + 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= 2'd0;
      sel_pulse <= 1'b0;
      btn_state <= 1'b0;
    end else begin
      sel       <= sel_d;
      sel_pulse <= step;
      btn_state <= btn_state_d;
    end
  end

  assign dbg_state = state;

endmodule
